// File: rtl/mips_cpu_control_seq.sv
// mips_cpu_control_seq
// Multi-cycle sequencer for the MIPS CPU. Steps each instruction through
// FETCH, EXEC, MEM, WB and MULDIV, stalls bus accesses on waitrequest,
// times the HI/LO unit, handles the optional branch delay slot and stops
// the core when a fetch hits HALT_ADDR.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   waitrequest         memory busy, hold the current access
//   Instr               instruction register (valid from EXEC onward)
//   ALUCond             branch condition, used in EXEC
//   DecRegWrite         decoder register-write request
//   PCCurrent           architectural PC (halt detection)
//   active, State       core running flag and current state
//   Ctrl*               strobes for bus, IR, PC, register file and HI/LO
module mips_cpu_control_seq #(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter bit          DELAY_SLOT    = 1'b1,
    parameter logic [31:0] HALT_ADDR     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic [31:0] Instr,
    input  logic        ALUCond,
    input  logic        DecRegWrite,
    input  logic [31:0] PCCurrent,
    output logic        active,
    output logic [2:0]  State,
    output logic        CtrlMemRead,
    output logic        CtrlMemWrite,
    output logic        CtrlAddrSel,
    output logic        CtrlIRWrite,
    output logic        CtrlPCWrite,
    output logic [1:0]  CtrlPCSel,
    output logic        CtrlBTLatch,
    output logic        CtrlRegWriteEn,
    output logic        CtrlSpcStart,
    output logic        CtrlSpcRegWriteEn
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MULDIV = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_ALU    = 3'd0,
        C_LOAD   = 3'd1,
        C_STORE  = 3'd2,
        C_MULDIV = 3'd3,
        C_JUMP   = 3'd4,
        C_BRANCH = 3'd5
    } iclass_t;

    localparam logic [5:0] MD_LOAD = 6'(MULDIV_CYCLES - 32'd1);

    // Coarse instruction class from opcode and SPECIAL funct field.
    function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] fn);
        iclass_t c;
        case (op)
            6'd0: begin
                case (fn)
                    6'd8, 6'd9:                   c = C_JUMP;
                    6'd24, 6'd25, 6'd26, 6'd27:   c = C_MULDIV;
                    default:                      c = C_ALU;
                endcase
            end
            6'd1, 6'd4, 6'd5, 6'd6, 6'd7:         c = C_BRANCH;
            6'd2, 6'd3:                           c = C_JUMP;
            6'd32, 6'd33, 6'd34, 6'd35,
            6'd36, 6'd37, 6'd38:                  c = C_LOAD;
            6'd40, 6'd41, 6'd43:                  c = C_STORE;
            default:                              c = C_ALU;
        endcase
        return c;
    endfunction

    state_t     state_r;
    logic       pending_r;
    logic [5:0] cnt_r;
    logic       active_r;

    iclass_t    cls_s;
    logic       taken_s;
    logic       halt_s;
    logic       latch_s;
    logic [1:0] sel_s;
    logic       unused_s;

    assign unused_s = ^{Instr[25:6]};
    assign State    = state_r;
    assign active   = active_r;

    // Decode helpers shared by the next-state and strobe logic.
    always_comb begin
        cls_s   = classify(Instr[31:26], Instr[5:0]);
        taken_s = (cls_s == C_JUMP) || ((cls_s == C_BRANCH) && ALUCond);
        halt_s  = (PCCurrent == HALT_ADDR) && !pending_r;
        // A branch sitting in a delay slot never re-latches its target.
        latch_s = (state_r == S_EXEC) && taken_s && DELAY_SLOT && !pending_r;
        if (pending_r) begin
            sel_s = 2'd1;
        end else if ((state_r == S_EXEC) && taken_s && !DELAY_SLOT) begin
            sel_s = 2'd2;
        end else begin
            sel_s = 2'd0;
        end
    end

    // State, delay-slot flag, MULDIV counter and run flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            pending_r <= 1'b0;
            cnt_r     <= 6'd0;
            active_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r  <= S_FETCH;
                    active_r <= 1'b1;
                end
                S_FETCH: begin
                    if (halt_s) begin
                        state_r  <= S_HALTED;
                        active_r <= 1'b0;
                    end else if (!waitrequest) begin
                        state_r <= S_EXEC;
                    end else begin
                        state_r <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    case (cls_s)
                        C_LOAD, C_STORE: state_r <= S_MEM;
                        C_MULDIV: begin
                            cnt_r   <= MD_LOAD;
                            state_r <= S_MULDIV;
                        end
                        default: begin
                            // Commit: sets the flag on a fresh taken branch,
                            // clears it when this is the delay-slot instruction.
                            pending_r <= latch_s;
                            state_r   <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (waitrequest) begin
                        state_r <= S_MEM;
                    end else if (cls_s == C_STORE) begin
                        pending_r <= 1'b0;
                        state_r   <= S_FETCH;
                    end else begin
                        state_r <= S_WB;
                    end
                end
                S_WB: begin
                    pending_r <= 1'b0;
                    state_r   <= S_FETCH;
                end
                S_MULDIV: begin
                    if (cnt_r == 6'd0) begin
                        pending_r <= 1'b0;
                        state_r   <= S_FETCH;
                    end else begin
                        cnt_r <= cnt_r - 6'd1;
                    end
                end
                S_HALTED: state_r <= S_HALTED;
                default:  state_r <= S_IDLE;
            endcase
        end
    end

    // Strobe decode from state and live inputs; IDLE and HALTED drive nothing.
    always_comb begin
        CtrlMemRead       = 1'b0;
        CtrlMemWrite      = 1'b0;
        CtrlAddrSel       = 1'b0;
        CtrlIRWrite       = 1'b0;
        CtrlPCWrite       = 1'b0;
        CtrlPCSel         = 2'd0;
        CtrlBTLatch       = 1'b0;
        CtrlRegWriteEn    = 1'b0;
        CtrlSpcStart      = 1'b0;
        CtrlSpcRegWriteEn = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (halt_s) begin
                    CtrlMemRead = 1'b0;
                end else begin
                    CtrlMemRead = 1'b1;
                    CtrlIRWrite = !waitrequest;
                end
            end
            S_EXEC: begin
                case (cls_s)
                    C_LOAD, C_STORE: CtrlSpcStart = 1'b0;
                    C_MULDIV:        CtrlSpcStart = 1'b1;
                    default: begin
                        CtrlRegWriteEn = DecRegWrite;
                        CtrlPCWrite    = 1'b1;
                        CtrlPCSel      = sel_s;
                        CtrlBTLatch    = latch_s;
                    end
                endcase
            end
            S_MEM: begin
                CtrlAddrSel = 1'b1;
                if (cls_s == C_STORE) begin
                    CtrlMemWrite = 1'b1;
                    CtrlPCWrite  = !waitrequest;
                    CtrlPCSel    = sel_s;
                end else begin
                    CtrlMemRead = 1'b1;
                end
            end
            S_WB: begin
                CtrlRegWriteEn = DecRegWrite;
                CtrlPCWrite    = 1'b1;
                CtrlPCSel      = sel_s;
            end
            S_MULDIV: begin
                if (cnt_r == 6'd0) begin
                    CtrlSpcRegWriteEn = 1'b1;
                    CtrlPCWrite       = 1'b1;
                    CtrlPCSel         = sel_s;
                end else begin
                    CtrlSpcRegWriteEn = 1'b0;
                end
            end
            default: CtrlPCWrite = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mips_cpu_control_seq.sv
// Testbench for mips_cpu_control_seq. Two instances: one with delay slot and
// a 5-cycle multiply, one without delay slot and a 1-cycle multiply. Only one
// runs at a time, the other is parked in reset. The bench acts as the
// datapath: it owns the PC, the latched branch target and the delay-slot
// flag, and expands each instruction into its expected cycle-by-cycle strobe
// pattern from its class, wait states and latency rules.
module tb_mips_cpu_control_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic        wreq  [2];
    logic        cond  [2];
    logic        decrw [2];
    logic [31:0] ins   [2];
    logic [31:0] pcc   [2];
    logic        act   [2];
    logic [2:0]  st    [2];
    logic        mr    [2];
    logic        mw    [2];
    logic        asel  [2];
    logic        irw   [2];
    logic        pcw   [2];
    logic [1:0]  psel  [2];
    logic        bt    [2];
    logic        rwe   [2];
    logic        ss    [2];
    logic        srw   [2];

    mips_cpu_control_seq #(.MULDIV_CYCLES(5), .DELAY_SLOT(1'b1), .HALT_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .reset(rst[0]), .waitrequest(wreq[0]), .Instr(ins[0]), .ALUCond(cond[0]),
        .DecRegWrite(decrw[0]), .PCCurrent(pcc[0]), .active(act[0]), .State(st[0]),
        .CtrlMemRead(mr[0]), .CtrlMemWrite(mw[0]), .CtrlAddrSel(asel[0]), .CtrlIRWrite(irw[0]),
        .CtrlPCWrite(pcw[0]), .CtrlPCSel(psel[0]), .CtrlBTLatch(bt[0]), .CtrlRegWriteEn(rwe[0]),
        .CtrlSpcStart(ss[0]), .CtrlSpcRegWriteEn(srw[0]));

    mips_cpu_control_seq #(.MULDIV_CYCLES(1), .DELAY_SLOT(1'b0), .HALT_ADDR(32'h0000_0000)) dut1 (
        .clk(clk), .reset(rst[1]), .waitrequest(wreq[1]), .Instr(ins[1]), .ALUCond(cond[1]),
        .DecRegWrite(decrw[1]), .PCCurrent(pcc[1]), .active(act[1]), .State(st[1]),
        .CtrlMemRead(mr[1]), .CtrlMemWrite(mw[1]), .CtrlAddrSel(asel[1]), .CtrlIRWrite(irw[1]),
        .CtrlPCWrite(pcw[1]), .CtrlPCSel(psel[1]), .CtrlBTLatch(bt[1]), .CtrlRegWriteEn(rwe[1]),
        .CtrlSpcStart(ss[1]), .CtrlSpcRegWriteEn(srw[1]));

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_MD = 3, K_JUMP = 4, K_BR = 5;
    localparam logic [31:0] I_ADDU = 32'h0085_1021;
    localparam logic [31:0] I_LW   = 32'h8C82_0004;
    localparam logic [31:0] I_SW   = 32'hAC82_0004;
    localparam logic [31:0] I_MULT = 32'h0085_0018;
    localparam logic [31:0] I_BEQ  = 32'h1085_0003;
    localparam logic [31:0] I_JR   = 32'h0080_0008;
    localparam logic [31:0] I_J    = 32'h0800_0010;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mdc [2]  = '{5, 1};
    bit          ds  [2]  = '{1'b1, 1'b0};
    logic [31:0] pc_m;
    logic [31:0] lt_m;
    bit          pend_m;
    bit          aborted;
    int          abort_cnt;

    function automatic int classify(input logic [31:0] i);
        logic [5:0] op;
        logic [5:0] fn;
        op = i[31:26];
        fn = i[5:0];
        if (op inside {[6'd32:6'd38]}) return K_LOAD;
        if (op inside {6'd40, 6'd41, 6'd43}) return K_STORE;
        if (op inside {6'd1, [6'd4:6'd7]}) return K_BR;
        if (op inside {6'd2, 6'd3}) return K_JUMP;
        if (op == 6'd0 && (fn inside {6'd8, 6'd9})) return K_JUMP;
        if (op == 6'd0 && (fn inside {[6'd24:6'd27]})) return K_MD;
        return K_ALU;
    endfunction

    // {State, active, MemRead, MemWrite, AddrSel, IRWrite, PCWrite, PCSel, BTLatch, RegWriteEn, SpcStart, SpcRegWriteEn}
    function automatic logic [14:0] mk(input int s, input int a, input int rd, input int wr, input int as,
                                       input int ir, input int pw, input int ps, input int bl, input int rw,
                                       input int sst, input int sr);
        return {s[2:0], a[0], rd[0], wr[0], as[0], ir[0], pw[0], ps[1:0], bl[0], rw[0], sst[0], sr[0]};
    endfunction

    function automatic logic [14:0] obs(input int d);
        return {st[d], act[d], mr[d], mw[d], asel[d], irw[d], pcw[d], psel[d], bt[d], rwe[d], ss[d], srw[d]};
    endfunction

    // Next-PC select only matters on a PC commit, so it is ignored otherwise.
    task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
        logic [14:0] m;
        m = e[6] ? 15'h7FFF : 15'h7FCF;
        n_checks++;
        assert ((o & m) === (e & m))
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, advance to the next falling edge.
    task automatic step(input int d, input logic w, input logic [31:0] iw, input logic [14:0] e, input string tag);
        if (aborted) return;
        wreq[d] = w;
        ins[d]  = iw;
        pcc[d]  = pc_m;
        #1;
        chk(tag, obs(d), e);
        if (abort_cnt > 0) begin
            abort_cnt--;
            if (abort_cnt == 0) begin
                aborted = 1'b1;
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1; wreq[d] = 1'b0; ins[d] = 32'd0; cond[d] = 1'b0; decrw[d] = 1'b0; pcc[d] = 32'd0;
        #1;
        chk($sformatf("d%0d reset", d), obs(d), 15'd0);
        @(negedge clk);
        chk($sformatf("d%0d reset-held", d), obs(d), 15'd0);
        rst[d] = 1'b0;
        aborted = 1'b0; abort_cnt = 0;
        pc_m = 32'hBFC0_0000; pend_m = 1'b0; lt_m = 32'd0;
        step(d, 1'b0, 32'd0, mk(0,0,0,0,0,0,0,0,0,0,0,0), $sformatf("d%0d idle", d));
    endtask

    task automatic run_instr(input int d, input logic [31:0] iw, input int c, input int rw,
                             input int fw, input int mwt, input logic [31:0] tgt, input string nm);
        int          k;
        bit          taken;
        int          csel;
        int          btl;
        bit          newpend;
        logic [31:0] nxt;
        k = classify(iw);
        taken = (k == K_JUMP) || (k == K_BR && c != 0);
        cond[d] = 1'(c);
        decrw[d] = 1'(rw);
        btl = 0;
        newpend = 1'b0;
        if (pend_m) begin
            csel = 1; nxt = lt_m;
        end else if (taken && ds[d]) begin
            csel = 0; btl = 1; newpend = 1'b1; nxt = pc_m + 32'd4;
        end else if (taken) begin
            csel = 2; nxt = tgt;
        end else begin
            csel = 0; nxt = pc_m + 32'd4;
        end
        for (int i = 0; i < fw; i++)
            step(d, 1'b1, $urandom, mk(1,1,1,0,0,0,0,0,0,0,0,0), $sformatf("d%0d %s fetch-wait", d, nm));
        step(d, 1'b0, $urandom, mk(1,1,1,0,0,1,0,0,0,0,0,0), $sformatf("d%0d %s fetch", d, nm));
        case (k)
            K_LOAD, K_STORE: begin
                step(d, 1'b0, iw, mk(2,1,0,0,0,0,0,0,0,0,0,0), $sformatf("d%0d %s exec", d, nm));
                for (int i = 0; i < mwt; i++)
                    step(d, 1'b1, iw, mk(3,1,int'(k == K_LOAD),int'(k == K_STORE),1,0,0,0,0,0,0,0),
                         $sformatf("d%0d %s mem-wait", d, nm));
                if (k == K_LOAD) begin
                    step(d, 1'b0, iw, mk(3,1,1,0,1,0,0,0,0,0,0,0), $sformatf("d%0d %s mem", d, nm));
                    step(d, 1'b0, iw, mk(4,1,0,0,0,0,1,csel,0,rw,0,0), $sformatf("d%0d %s wb", d, nm));
                end else begin
                    step(d, 1'b0, iw, mk(3,1,0,1,1,0,1,csel,0,0,0,0), $sformatf("d%0d %s mem", d, nm));
                end
            end
            K_MD: begin
                step(d, 1'b0, iw, mk(2,1,0,0,0,0,0,0,0,0,1,0), $sformatf("d%0d %s exec", d, nm));
                for (int i = 0; i < mdc[d] - 1; i++)
                    step(d, 1'b0, iw, mk(5,1,0,0,0,0,0,0,0,0,0,0), $sformatf("d%0d %s muldiv", d, nm));
                step(d, 1'b0, iw, mk(5,1,0,0,0,0,1,csel,0,0,0,1), $sformatf("d%0d %s muldiv-end", d, nm));
            end
            default:
                step(d, 1'b0, iw, mk(2,1,0,0,0,0,1,csel,btl,rw,0,0), $sformatf("d%0d %s exec", d, nm));
        endcase
        if (!aborted) begin
            pc_m = nxt;
            pend_m = newpend;
            if (btl != 0) lt_m = tgt;
        end
    endtask

    task automatic expect_halt(input int d);
        step(d, 1'b0, $urandom, mk(1,1,0,0,0,0,0,0,0,0,0,0), $sformatf("d%0d halt-fetch", d));
        for (int i = 0; i < 3; i++)
            step(d, 1'($urandom_range(0, 1)), $urandom, mk(6,0,0,0,0,0,0,0,0,0,0,0), $sformatf("d%0d halted", d));
    endtask

    task automatic rand_run(input int d, input int n);
        logic [31:0] iw;
        logic [5:0]  op;
        logic [5:0]  fn;
        for (int i = 0; i < n; i++) begin
            iw = $urandom;
            fn = iw[5:0];
            case ($urandom_range(0, 8))
                0: begin op = 6'd0; fn = 6'($urandom_range(32, 43)); end
                1: begin op = 6'd0; fn = 6'($urandom_range(8, 9)); end
                2: op = 6'($urandom_range(32, 38));
                3: begin op = 6'd40; if ($urandom_range(0, 1) == 1) op = 6'd43; end
                4: op = 6'($urandom_range(4, 7));
                5: op = 6'($urandom_range(1, 3));
                6: op = 6'($urandom_range(0, 63));
                7: begin op = 6'd0; fn = 6'($urandom_range(24, 27)); end
                default: op = 6'($urandom_range(8, 15));
            endcase
            iw[31:26] = op;
            iw[5:0] = fn;
            run_instr(d, iw, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      32'h0040_0000 | ($urandom & 32'h000F_FFFC), "rand");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; wreq[d] = 1'b0; cond[d] = 1'b0; decrw[d] = 1'b0; ins[d] = 32'd0; pcc[d] = 32'd0;
        end
        aborted = 1'b0; abort_cnt = 0; pc_m = 32'd0; lt_m = 32'd0; pend_m = 1'b0;
        @(negedge clk);

        // Delay-slot instance, 5-cycle multiply
        do_reset(0);
        run_instr(0, I_ADDU, 0, 1, 0, 0, 32'd0, "addu");
        run_instr(0, I_LW,   0, 1, 0, 3, 32'd0, "lw-wait");
        run_instr(0, I_MULT, 0, 0, 0, 0, 32'd0, "mult");
        run_instr(0, I_BEQ,  1, 0, 0, 0, 32'h0040_0100, "beq-ds");
        run_instr(0, I_ADDU, 0, 1, 0, 0, 32'd0, "slot");
        run_instr(0, I_SW,   0, 1, 2, 1, 32'd0, "sw-wait");
        run_instr(0, I_J,    0, 0, 0, 0, 32'hFFFF_FFFC, "j-top");
        run_instr(0, I_ADDU, 0, 0, 1, 0, 32'd0, "slot2");
        run_instr(0, I_J,    0, 0, 0, 0, 32'h0040_0200, "j-wrap");
        run_instr(0, I_LW,   0, 1, 0, 1, 32'd0, "slot-at-halt-pc");
        run_instr(0, I_BEQ,  0, 0, 0, 0, 32'h0040_0300, "beq-nt");
        rand_run(0, 40);
        abort_cnt = 5;
        run_instr(0, I_MULT, 0, 0, 0, 0, 32'd0, "mult-abort");
        do_reset(0);
        run_instr(0, I_ADDU, 0, 1, 0, 0, 32'd0, "addu2");
        run_instr(0, I_JR,   0, 0, 0, 0, 32'd0, "jr-zero");
        run_instr(0, I_ADDU, 0, 1, 0, 0, 32'd0, "slot3");
        expect_halt(0);
        rst[0] = 1'b1;

        // No delay slot, single-cycle multiply
        do_reset(1);
        run_instr(1, I_ADDU, 0, 0, 0, 0, 32'd0, "addu");
        run_instr(1, I_BEQ,  1, 0, 0, 0, 32'h0040_0400, "beq-taken");
        run_instr(1, I_BEQ,  0, 1, 0, 0, 32'h0040_0500, "beq-nt");
        run_instr(1, I_MULT, 0, 0, 1, 0, 32'd0, "mult1");
        run_instr(1, I_SW,   0, 0, 0, 2, 32'd0, "sw");
        run_instr(1, I_LW,   0, 0, 0, 0, 32'd0, "lw");
        rand_run(1, 40);
        run_instr(1, I_J,    0, 0, 0, 0, 32'd0, "j-zero");
        expect_halt(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_control_seq.md
# mips_cpu_control_seq

Multi-cycle sequencer for the MIPS CPU, placed beside the combinational instruction decoder. It steps each instruction through FETCH, EXEC, MEM, WB and MULDIV states, holds memory accesses while `waitrequest` is high, and counts a parametrised multiply/divide latency. It also implements the optional branch delay slot and detects the halt address. Its outputs gate the decoder's write enables and drive the PC and IR register strobes.

## Interface
- `MULDIV_CYCLES`, 32: cycles spent in MULDIV; legal range 1..63.
- `DELAY_SLOT`, 1: 1 = MIPS delay-slot semantics; 0 = taken branch or jump redirects PC immediately.
- `HALT_ADDR`, 32'h0000_0000: a fetch from this PC halts the core.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `waitrequest`  in  1  memory busy; the current access must be held.
- `Instr`  in  32  instruction register contents; valid from EXEC onward.
- `ALUCond`  in  1  branch condition from ALU; sampled in EXEC.
- `DecRegWrite`  in  1  decoder's register-write request.
- `PCCurrent`  in  32  architectural PC.
- `active`  out  1  core running.
- `State`  out  3  IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, MULDIV=5, HALTED=6.
- `CtrlMemRead`, `CtrlMemWrite`  out  1  bus strobes.
- `CtrlAddrSel`  out  1  address source: 0 = PC, 1 = ALU result.
- `CtrlIRWrite`  out  1  capture readdata into IR.
- `CtrlPCWrite`  out  1  commit next PC.
- `CtrlPCSel`  out  2  next-PC source: 0 = PC+4, 1 = latched branch target, 2 = target computed this cycle.
- `CtrlBTLatch`  out  1  datapath latches the computed target.
- `CtrlRegWriteEn`  out  1  gated register-file write.
- `CtrlSpcStart`, `CtrlSpcRegWriteEn`  out  1  HI/LO unit start pulse and completion write.

## Operation
- **Instruction classes**, decoded from `Instr[31:26]` and `Instr[5:0]`:
  - load: opcodes 32–38.
  - store: opcodes 40, 41, 43.
  - muldiv: SPECIAL with funct 24–27.
  - jump: opcodes 2, 3, or SPECIAL with funct 8, 9; always taken.
  - branch: opcodes 1, 4–7; taken iff `ALUCond` = 1.
  - alu: everything else, including undefined opcodes.
- **IDLE**: entered on reset. Next cycle goes to FETCH and `active` becomes 1.
- **FETCH**:
  - If `PCCurrent` == `HALT_ADDR` and `pending` = 0, go to HALTED; no bus access occurs.
  - Otherwise drive `CtrlMemRead` = 1 with `CtrlAddrSel` = 0.
  - Hold while `waitrequest` = 1.
  - When `waitrequest` = 0, drive `CtrlIRWrite` = 1 for one cycle and go to EXEC.
- **EXEC**:
  - alu or jump/branch: `CtrlRegWriteEn` = `DecRegWrite`, `CtrlPCWrite` = 1, then go to FETCH.
  - load/store: go to MEM.
  - muldiv: drive `CtrlSpcStart` = 1, load counter = `MULDIV_CYCLES`−1, go to MULDIV.
- **Taken jump/branch in EXEC**:
  - `DELAY_SLOT` = 1: `CtrlBTLatch` = 1, set `pending`, `CtrlPCSel` = 0.
  - `DELAY_SLOT` = 0: `CtrlPCSel` = 2.
- **Any PC commit while `pending` = 1** (EXEC, MEM store, WB, MULDIV end): `CtrlPCSel` = 1, and `pending` clears.
  - A taken branch in the delay slot is not re-latched; `CtrlBTLatch` is suppressed.
- **MEM**:
  - `CtrlAddrSel` = 1, strobe = class (read for load, write for store).
  - Hold while `waitrequest` = 1.
  - On release: store commits PC and goes to FETCH; load goes to WB.
- **WB**: `CtrlRegWriteEn` = `DecRegWrite`, `CtrlPCWrite` = 1, then go to FETCH.
- **MULDIV**:
  - Counter decrements each cycle.
  - When the counter = 0: `CtrlSpcRegWriteEn` = 1, `CtrlPCWrite` = 1, then go to FETCH.
  - `MULDIV_CYCLES` = 1 means exactly one MULDIV cycle.
- **HALTED**: all strobes 0, `active` = 0. Leaves only via reset.
- **Output decoding**: all strobes are decoded from state and inputs; never more than one of `CtrlMemRead`/`CtrlMemWrite` is high.

## Timing
- **Reset** (asynchronous, effective immediately, including mid-MEM or mid-MULDIV):
  - state IDLE, `pending` 0, counter 0.
  - every output 0; `State` = 0.
- **Latency without wait states**:
  - alu/jump/branch: 2 cycles.
  - store: 3 cycles.
  - load: 4 cycles.
  - muldiv: 2 + `MULDIV_CYCLES` cycles.
- Each `waitrequest` = 1 cycle adds exactly one cycle. Strobe and address select stay stable throughout the wait.
- `CtrlPCWrite`, `CtrlIRWrite`, `CtrlSpcStart` and `CtrlSpcRegWriteEn` are single-cycle pulses, exactly one per instruction.
- **Halt detection** happens in the first FETCH cycle. `active` falls on the next edge.

## Test plan
- Reset released, `PCCurrent` = 0xBFC00000, ADDU instruction, `waitrequest` = 0 → `State` sequence 0,1,2,1; `CtrlRegWriteEn` is high in cycle 3 only; `active` = 1 from cycle 2.
- LW with `waitrequest` high for 3 cycles during MEM → MEM lasts 4 cycles with `CtrlMemRead` = 1 and `CtrlAddrSel` = 1 held; WB pulses `CtrlRegWriteEn`; total 7 cycles.
- MULT with `MULDIV_CYCLES` = 5 → `CtrlSpcStart` in EXEC, 5 MULDIV cycles, `CtrlSpcRegWriteEn` and `CtrlPCWrite` on the 5th MULDIV cycle.
- BEQ with `ALUCond` = 1, `DELAY_SLOT` = 1 → `CtrlBTLatch` = 1 and `CtrlPCSel` = 0; the next instruction commits with `CtrlPCSel` = 1. With `DELAY_SLOT` = 0 → `CtrlPCSel` = 2 in the BEQ's EXEC.
- JR to 0 with `DELAY_SLOT` = 1 → the delay-slot instruction executes, then the next FETCH sees `PCCurrent` = 0 → HALTED, `active` = 0, no `CtrlMemRead`.
- Reset asserted in the 3rd MULDIV cycle → all outputs 0 immediately; after release IDLE then FETCH; no `CtrlSpcRegWriteEn` is issued.
